// File: rtl/time_counter.sv
// BCD hour:minute:second counter advanced by rising edges of a 1 Hz strobe, with set mode and day tick.
// Optional alarm compiled in with `define TIME_COUNTER_ALARM_EN; ports are present in both builds.
module time_counter #(
    parameter logic [7:0] RESET_HR  = 8'h00,
    parameter logic [7:0] RESET_MIN = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_clk,
    input  logic       set_mode,
    input  logic       inc_hr,
    input  logic       inc_min,
    input  logic       alarm_arm,
    input  logic       alarm_ack,
    input  logic [7:0] alarm_hr,
    input  logic [7:0] alarm_min,
    output logic [7:0] hr,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       day_tick,
    output logic       alarm_ring
);

    // BCD increment that wraps to 00 after reaching top.
    function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] top);
        if (v == top)         return 8'h00;
        if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic       sec_q;
    logic       tick;
    logic       sec_wrap, min_wrap;
    logic [7:0] sec_nx, min_nx, hr_nx;
    logic       day_nx;

    assign tick     = sec_clk & ~sec_q;
    assign sec_wrap = (sec == 8'h59);
    assign min_wrap = (min == 8'h59);

    always_comb begin
        sec_nx = sec;
        min_nx = min;
        hr_nx  = hr;
        day_nx = 1'b0;
        if (set_mode) begin
            // Ticks are dropped while setting; min does not carry into hr here.
            sec_nx = 8'h00;
            if (inc_min) min_nx = inc_bcd(min, 8'h59);
            if (inc_hr)  hr_nx  = inc_bcd(hr, 8'h23);
        end else if (tick) begin
            sec_nx = inc_bcd(sec, 8'h59);
            if (sec_wrap) begin
                min_nx = inc_bcd(min, 8'h59);
                if (min_wrap) begin
                    hr_nx  = inc_bcd(hr, 8'h23);
                    day_nx = (hr == 8'h23);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // sec_q=1 masks a strobe that is already high when reset releases.
            sec_q    <= 1'b1;
            sec      <= 8'h00;
            min      <= RESET_MIN;
            hr       <= RESET_HR;
            day_tick <= 1'b0;
        end else begin
            sec_q    <= sec_clk;
            sec      <= sec_nx;
            min      <= min_nx;
            hr       <= hr_nx;
            day_tick <= day_nx;
        end
    end

`ifdef TIME_COUNTER_ALARM_EN
    logic min_chg;
    logic ring_set, ring_clr;

    assign min_chg  = ~set_mode & tick & sec_wrap;
    assign ring_set = min_chg & alarm_arm & (min_nx == alarm_min) & (hr_nx == alarm_hr);
    // Any clear source, including the one-minute timeout, wins over a set.
    assign ring_clr = alarm_ack | ~alarm_arm | set_mode | (alarm_ring & min_chg);

    always_ff @(posedge clk) begin
        if (rst)           alarm_ring <= 1'b0;
        else if (ring_clr) alarm_ring <= 1'b0;
        else if (ring_set) alarm_ring <= 1'b1;
    end
`else
    logic alarm_unused;
    assign alarm_unused = ^{alarm_arm, alarm_ack, alarm_hr, alarm_min};
    assign alarm_ring   = 1'b0;
`endif

endmodule
